spi_transaction_sequencer: RTL and testbench
============================================

// Module: spi_transaction_sequencer
// PURPOSE
//  Multi-byte front end for the SPI byte controller; sits directly upstream of it.
//  Buffers host TX bytes in a FIFO, frames an N-byte transaction with chip select,
//  feeds the controller one byte per handshake and collects received bytes in an RX FIFO.
//  The host writes bytes, pulses start and later pops the response.
// PARAMETERS
//  FIFO_DEPTH   16  entries per FIFO (TX and RX); power of two, >= 2
//  LEN_W         8  width of transaction byte count
//  CS_SETUP      2  i_clk cycles from o_cs_n low to first byte issue (>= 1)
//  CS_HOLD       2  i_clk cycles from last rx byte to o_cs_n high (>= 1)
// PORTS
//  i_clk            in   1      system clock
//  i_rst            in   1      reset, asynchronous, active-high
//  i_tx_data        in   8      host TX byte
//  i_tx_wr          in   1      push i_tx_data into TX FIFO (ignored when o_tx_full)
//  o_tx_full        out  1      TX FIFO full
//  i_start          in   1      begin transaction (accepted only in IDLE)
//  i_len            in   LEN_W  bytes in transaction, sampled with i_start
//  o_rx_data        out  8      RX FIFO head (valid when !o_rx_empty)
//  i_rx_rd          in   1      pop RX FIFO (ignored when o_rx_empty)
//  o_rx_empty       out  1      RX FIFO empty
//  o_rx_overflow    out  1      sticky: RX byte dropped; cleared on accepted start
//  o_busy           out  1      high in every state except IDLE
//  o_done           out  1      one-cycle pulse at transaction end
//  o_cs_n           out  1      SPI chip select, active-low
//  o_ctl_tx         out  8      byte to controller
//  o_ctl_tx_valid   out  1      one-cycle pulse, byte offered to controller
//  i_ctl_ready      in   1      controller idle
//  i_ctl_rx         in   8      byte from controller
//  i_ctl_rx_valid   in   1      controller rx byte valid (single-cycle)
// BEHAVIOUR
//  Reset: state IDLE; both FIFOs empty; o_cs_n=1; o_ctl_tx=0, o_ctl_tx_valid=0;
//   o_done=0; o_rx_overflow=0; o_busy=0; o_tx_full=0; o_rx_empty=1. All outputs registered
//   or decoded from registers; reset mid-transaction aborts at once, FIFO contents lost.
//  FSM (one-hot): IDLE, SETUP, ISSUE, WAIT, HOLD, DONE.
//   IDLE : i_start & i_len!=0 -> latch count=i_len, clear overflow, cs_n<=0, SETUP.
//          i_start & i_len==0 -> DONE (no CS activity). i_start outside IDLE ignored.
//   SETUP: count CS_SETUP cycles -> ISSUE.
//   ISSUE: when i_ctl_ready & TX FIFO non-empty: next cycle o_ctl_tx=head,
//          o_ctl_tx_valid=1 (one cycle), pop TX FIFO -> WAIT. TX FIFO empty: stall here
//          with CS held low (underrun stall; no filler bytes).
//   WAIT : i_ctl_ready ignored; on i_ctl_rx_valid push i_ctl_rx to RX FIFO
//          (if full: drop, set o_rx_overflow), count--. count==0 -> HOLD, else ISSUE.
//   HOLD : CS_HOLD cycles, then cs_n<=1 -> DONE.
//   DONE : o_done=1 for exactly this cycle -> IDLE.
//  FIFOs: TX push and pop in same cycle allowed at any level including full (count
//   unchanged); same for RX. Pointers wrap modulo FIFO_DEPTH; occupancy counter is
//   $clog2(FIFO_DEPTH)+1 bits. Host may push TX bytes during a transaction.
//  Byte order: TX FIFO head transmitted first; RX bytes stored in reception order.
//  Min gap between bytes is set by controller ready turnaround; no extra wait inserted.
// STRUCTURE
//  Shared package: FSM state localparams, SPI byte width (8).
//  One sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/data),
//   instantiated twice for TX and RX. FSM, counters, CS logic stay in this module.
// TESTING
//  Bench pairs this block with a behavioural controller model (loopback: rx=~tx).
//  1 push A5,3C,FF; start len=3 -> cs_n low, 3 valid pulses A5,3C,FF, RX=5A,C3,00,
//    cs_n high after CS_HOLD, one o_done pulse, o_busy low afterwards.
//  2 start len=0 -> o_done one cycle later-ish (via DONE), cs_n never low, FIFOs unchanged.
//  3 start len=2 with only 1 byte queued -> stall in ISSUE, cs_n low; push 2nd byte
//    -> transaction completes with 2 RX bytes.
//  4 RX FIFO pre-filled to FIFO_DEPTH; 1-byte transaction -> byte dropped,
//    o_rx_overflow=1; next accepted start clears it.
//  5 assert i_rst in WAIT -> same cycle cs_n=1, o_busy=0, FIFOs empty; new start works.
//  6 TX FIFO full, simultaneous i_tx_wr with ISSUE pop -> entry accepted, count stays full.

Source files
------------

// File: rtl/spi_transaction_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: byte width and
// one-hot FSM state encoding.
package spi_transaction_sequencer_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_SETUP = 6'b000010,
    ST_ISSUE = 6'b000100,
    ST_WAIT  = 6'b001000,
    ST_HOLD  = 6'b010000,
    ST_DONE  = 6'b100000
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_transaction_sequencer_sync_fifo.sv
// Synchronous FIFO with occupancy counter; a push is accepted when full
// as long as a pop happens in the same cycle.
module sync_fifo
  import spi_transaction_sequencer_pkg::*;
#(
  parameter int WIDTH = SPI_BYTE_W,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_o   = (count_q == CNT_W'(0));
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while the counter says empty.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Multi-byte SPI front end: frames an N-byte transaction with chip select and
// hands bytes to the byte controller one handshake at a time.
module spi_transaction_sequencer
  import spi_transaction_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [SPI_BYTE_W-1:0] i_tx_data,
  input  logic                  i_tx_wr,
  output logic                  o_tx_full,
  input  logic                  i_start,
  input  logic [LEN_W-1:0]      i_len,
  output logic [SPI_BYTE_W-1:0] o_rx_data,
  input  logic                  i_rx_rd,
  output logic                  o_rx_empty,
  output logic                  o_rx_overflow,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cs_n,
  output logic [SPI_BYTE_W-1:0] o_ctl_tx,
  output logic                  o_ctl_tx_valid,
  input  logic                  i_ctl_ready,
  input  logic [SPI_BYTE_W-1:0] i_ctl_rx,
  input  logic                  i_ctl_rx_valid
);

  localparam int TMR_W = $clog2(max2(CS_SETUP, CS_HOLD) + 1);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      count_q, count_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic                  cs_n_q, cs_n_d;
  logic [SPI_BYTE_W-1:0] ctl_tx_q, ctl_tx_d;
  logic                  ctl_tx_valid_q, ctl_tx_valid_d;
  logic                  rx_overflow_q, rx_overflow_d;
  logic                  tx_pop_s, rx_push_s, tx_empty_s, rx_full_s;
  logic [SPI_BYTE_W-1:0] tx_head_s;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(i_tx_wr), .pop_i(tx_pop_s),
    .data_i(i_tx_data), .data_o(tx_head_s), .full_o(o_tx_full), .empty_o(tx_empty_s)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(i_clk), .rst_i(i_rst), .push_i(rx_push_s), .pop_i(i_rx_rd),
    .data_i(i_ctl_rx), .data_o(o_rx_data), .full_o(rx_full_s), .empty_o(o_rx_empty)
  );

  // Next-state and datapath decode for the transaction FSM.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    timer_d        = timer_q;
    cs_n_d         = cs_n_q;
    ctl_tx_d       = ctl_tx_q;
    ctl_tx_valid_d = 1'b0;
    rx_overflow_d  = rx_overflow_q;
    tx_pop_s       = 1'b0;
    rx_push_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rx_overflow_d = 1'b0;
          if (i_len != LEN_W'(0)) begin
            count_d = i_len;
            timer_d = TMR_W'(0);
            cs_n_d  = 1'b0;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (timer_q == TMR_W'(CS_SETUP - 1)) state_d = ST_ISSUE;
        else                                 timer_d = timer_q + TMR_W'(1);
      end
      ST_ISSUE: begin
        // An empty TX FIFO stalls here with CS still asserted.
        if (i_ctl_ready && !tx_empty_s) begin
          tx_pop_s       = 1'b1;
          ctl_tx_d       = tx_head_s;
          ctl_tx_valid_d = 1'b1;
          state_d        = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (i_ctl_rx_valid) begin
          rx_push_s = 1'b1;
          if (rx_full_s && !i_rx_rd) rx_overflow_d = 1'b1;
          else                       rx_overflow_d = rx_overflow_q;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            timer_d = TMR_W'(0);
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (timer_q == TMR_W'(CS_HOLD - 1)) begin
          cs_n_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      timer_q        <= '0;
      cs_n_q         <= 1'b1;
      ctl_tx_q       <= '0;
      ctl_tx_valid_q <= 1'b0;
      rx_overflow_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      timer_q        <= timer_d;
      cs_n_q         <= cs_n_d;
      ctl_tx_q       <= ctl_tx_d;
      ctl_tx_valid_q <= ctl_tx_valid_d;
      rx_overflow_q  <= rx_overflow_d;
    end
  end

  assign o_cs_n         = cs_n_q;
  assign o_ctl_tx       = ctl_tx_q;
  assign o_ctl_tx_valid = ctl_tx_valid_q;
  assign o_rx_overflow  = rx_overflow_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for spi_transaction_sequencer with a loopback byte-controller
// model that answers each offered byte with its complement three cycles later.
module tb_spi_transaction_sequencer;

  localparam int DEPTH    = 16;
  localparam int LEN_W    = 8;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       tx_data;
  logic             tx_wr;
  logic             tx_full;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       rx_data;
  logic             rx_rd;
  logic             rx_empty;
  logic             rx_overflow;
  logic             busy;
  logic             done;
  logic             cs_n;
  logic [7:0]       ctl_tx;
  logic             ctl_tx_valid;
  logic             ctl_ready;
  logic [7:0]       ctl_rx;
  logic             ctl_rx_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_seen [$];
  int         done_cnt = 0;
  int         hold_cnt = 0;
  int         cs_err = 0;
  bit         cs_low_seen = 1'b0;
  int         lat;
  logic [7:0] sh;

  spi_transaction_sequencer #(
    .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_wr(tx_wr),
    .o_tx_full(tx_full), .i_start(start), .i_len(len), .o_rx_data(rx_data),
    .i_rx_rd(rx_rd), .o_rx_empty(rx_empty), .o_rx_overflow(rx_overflow),
    .o_busy(busy), .o_done(done), .o_cs_n(cs_n), .o_ctl_tx(ctl_tx),
    .o_ctl_tx_valid(ctl_tx_valid), .i_ctl_ready(ctl_ready), .i_ctl_rx(ctl_rx),
    .i_ctl_rx_valid(ctl_rx_valid)
  );

  always #5 clk = ~clk;

  // Loopback controller model.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_ready    <= 1'b1;
      ctl_rx_valid <= 1'b0;
      ctl_rx       <= 8'h00;
      lat          <= 0;
      sh           <= 8'h00;
    end else begin
      ctl_rx_valid <= 1'b0;
      if (lat != 0) begin
        lat <= lat - 1;
        if (lat == 1) begin
          ctl_rx_valid <= 1'b1;
          ctl_rx       <= ~sh;
          ctl_ready    <= 1'b1;
        end
      end else if (ctl_tx_valid) begin
        ctl_ready <= 1'b0;
        sh        <= ctl_tx;
        lat       <= 3;
      end
    end
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (ctl_tx_valid) begin
      tx_seen.push_back(ctl_tx);
      if (cs_n) cs_err++;
    end
    if (done) done_cnt++;
    if (!cs_n) cs_low_seen = 1'b1;
    if (ctl_rx_valid) hold_cnt = 0;
    else if (!cs_n) hold_cnt++;
  end

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic start_txn(input logic [LEN_W-1:0] n);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pop_rx(output logic [7:0] d, output logic was_empty);
    d         = rx_data;
    was_empty = rx_empty;
    rx_rd     = 1'b1;
    @(negedge clk);
    rx_rd     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_data = 8'h00; tx_wr = 1'b0; start = 1'b0; len = '0; rx_rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", cs_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if ({tx_full, rx_empty, rx_overflow} !== 3'b010) begin errors++; $display("FAIL reset_flags got %b want 010", {tx_full, rx_empty, rx_overflow}); end
    checks++; if ({ctl_tx_valid, ctl_tx} !== 9'h000) begin errors++; $display("FAIL reset_ctl got %h want 000", {ctl_tx_valid, ctl_tx}); end
  endtask

  task automatic test_basic;
    logic [7:0] exp_tx [3] = '{8'hA5, 8'h3C, 8'hFF};
    logic [7:0] exp_rx [3] = '{8'h5A, 8'hC3, 8'h00};
    logic [7:0] d;
    logic       e;
    bit         ok;
    tx_seen.delete(); done_cnt = 0; cs_err = 0;
    for (int i = 0; i < 3; i++) push_tx(exp_tx[i]);
    start_txn(8'd3);
    checks++; if ({cs_n, busy} !== 2'b01) begin errors++; $display("FAIL basic_setup cs_n,busy got %b want 01", {cs_n, busy}); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL basic_cs_release got %b want 1", cs_n); end
    checks++; if (hold_cnt !== CS_HOLD) begin errors++; $display("FAIL basic_cs_hold got %0d want %0d", hold_cnt, CS_HOLD); end
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    checks++; if (cs_err !== 0) begin errors++; $display("FAIL basic_cs_during_byte got %0d want 0", cs_err); end
    checks++; if (tx_seen.size() !== 3) begin errors++; $display("FAIL basic_tx_count got %0d want 3", tx_seen.size()); end
    for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
      checks++; if (tx_seen[i] !== exp_tx[i]) begin errors++; $display("FAIL basic_tx[%0d] got %h want %h", i, tx_seen[i], exp_tx[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      pop_rx(d, e);
      checks++; if ({e, d} !== {1'b0, exp_rx[i]}) begin errors++; $display("FAIL basic_rx[%0d] got empty=%b %h want %h", i, e, d, exp_rx[i]); end
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL basic_rx_drained got %b want 1", rx_empty); end
  endtask

  task automatic test_len0;
    push_tx(8'h11);
    cs_low_seen = 1'b0; done_cnt = 0;
    start_txn(8'd0);
    checks++; if ({done, busy} !== 2'b11) begin errors++; $display("FAIL len0_done got done,busy=%b want 11", {done, busy}); end
    @(negedge clk);
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL len0_idle got done,busy=%b want 00", {done, busy}); end
    repeat (3) @(negedge clk);
    checks++; if (cs_low_seen !== 1'b0) begin errors++; $display("FAIL len0_cs got low_seen=%b want 0", cs_low_seen); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL len0_rx got empty=%b want 1", rx_empty); end
  endtask

  task automatic test_underrun;
    logic [7:0] d;
    logic       e;
    bit         ok;
    tx_seen.delete(); done_cnt = 0;
    start_txn(8'd2);
    repeat (30) @(negedge clk);
    checks++; if ({busy, cs_n, done_cnt[0]} !== 3'b100) begin errors++; $display("FAIL underrun_stall got busy,cs_n,done=%b want 100", {busy, cs_n, done_cnt[0]}); end
    checks++; if (tx_seen.size() !== 1) begin errors++; $display("FAIL underrun_sent got %0d want 1", tx_seen.size()); end
    push_tx(8'h22);
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL underrun_timeout got no done want done"); end
    checks++; if (tx_seen.size() !== 2 || tx_seen[0] !== 8'h11 || tx_seen[1] !== 8'h22) begin
      errors++; $display("FAIL underrun_tx got n=%0d want 11,22", tx_seen.size());
    end
    pop_rx(d, e);
    checks++; if ({e, d} !== 9'h0EE) begin errors++; $display("FAIL underrun_rx0 got %h want 0EE", {e, d}); end
    pop_rx(d, e);
    checks++; if ({e, d} !== 9'h0DD) begin errors++; $display("FAIL underrun_rx1 got %h want 0DD", {e, d}); end
  endtask

  task automatic test_overflow;
    logic [7:0] d;
    logic       e;
    bit         ok;
    for (int i = 0; i < DEPTH; i++) push_tx(8'(i));
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_tx_full got %b want 1", tx_full); end
    start_txn(8'd16);
    wait_done(400, ok);
    checks++; if ({ok, rx_empty, rx_overflow} !== 3'b100) begin errors++; $display("FAIL ovf_fill got ok,empty,ovf=%b want 100", {ok, rx_empty, rx_overflow}); end
    tx_seen.delete();
    push_tx(8'h80);
    start_txn(8'd1);
    wait_done(100, ok);
    checks++; if ({ok, rx_overflow} !== 2'b11) begin errors++; $display("FAIL ovf_set got ok,ovf=%b want 11", {ok, rx_overflow}); end
    checks++; if (tx_seen.size() !== 1 || tx_seen[0] !== 8'h80) begin errors++; $display("FAIL ovf_tx got n=%0d want 80", tx_seen.size()); end
    for (int i = 0; i < DEPTH; i++) begin
      pop_rx(d, e);
      checks++; if ({e, d} !== {1'b0, ~8'(i)}) begin errors++; $display("FAIL ovf_rx[%0d] got empty=%b %h want %h", i, e, d, ~8'(i)); end
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovf_dropped got empty=%b want 1", rx_empty); end
    push_tx(8'h01);
    start_txn(8'd1);
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", rx_overflow); end
    wait_done(100, ok);
    pop_rx(d, e);
    checks++; if ({ok, e, d} !== {2'b10, 8'hFE}) begin errors++; $display("FAIL ovf_after got ok,empty,data=%h want 2FE", {ok, e, d}); end
  endtask

  task automatic test_full_pushpop;
    logic [7:0] d;
    logic       e;
    bit         ok;
    for (int i = 0; i < DEPTH; i++) push_tx(8'h40 + 8'(i));
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_pre got %b want 1", tx_full); end
    start_txn(8'd1);
    repeat (2) @(negedge clk);
    tx_data = 8'hC9;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
    checks++; if ({ctl_tx_valid, ctl_tx} !== 9'h140) begin errors++; $display("FAIL full_pop_align got %h want 140", {ctl_tx_valid, ctl_tx}); end
    checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL full_stays got %b want 1", tx_full); end
    wait_done(100, ok);
    pop_rx(d, e);
    checks++; if ({ok, e, d} !== {2'b10, 8'hBF}) begin errors++; $display("FAIL full_rx got %h want 2BF", {ok, e, d}); end
    tx_seen.delete();
    start_txn(8'd16);
    wait_done(400, ok);
    checks++; if (!ok || tx_seen.size() !== 16 || tx_seen[0] !== 8'h41 || tx_seen[15] !== 8'hC9) begin
      errors++; $display("FAIL full_drain got ok=%b n=%0d want 41..4F,C9", ok, tx_seen.size());
    end
    for (int i = 0; i < 16; i++) pop_rx(d, e);
    checks++; if ({e, d, rx_empty} !== {1'b0, 8'h36, 1'b1}) begin errors++; $display("FAIL full_last_rx got %h want 06D", {e, d, rx_empty}); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic       e;
    bit         ok;
    bit         seen;
    push_tx(8'h5A);
    push_tx(8'h5B);
    start_txn(8'd2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ctl_tx_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_timeout got no valid want valid"); end
    rst = 1'b1;
    #1;
    checks++; if ({cs_n, busy, ctl_tx_valid} !== 3'b100) begin errors++; $display("FAIL rstmid_abort got cs_n,busy,valid=%b want 100", {cs_n, busy, ctl_tx_valid}); end
    checks++; if ({rx_empty, tx_full} !== 2'b10) begin errors++; $display("FAIL rstmid_fifos got empty,full=%b want 10", {rx_empty, tx_full}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_seen.delete();
    push_tx(8'h77);
    start_txn(8'd1);
    wait_done(100, ok);
    checks++; if (!ok || tx_seen.size() !== 1 || tx_seen[0] !== 8'h77) begin errors++; $display("FAIL rstmid_restart got ok=%b n=%0d want 77", ok, tx_seen.size()); end
    pop_rx(d, e);
    checks++; if ({e, d} !== 9'h088) begin errors++; $display("FAIL rstmid_rx got %h want 088", {e, d}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_underrun();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
